// File: rtl/score_drain_4x128.sv
// Drains the 64-entry FP32 score register file into 16 packed 128-bit score SRAM words.
// Optional per-word FP32 row maximum outputs are enabled with the SCORE_DRAIN_ROWMAX_EN macro.
module score_drain_4x128 #(
    parameter logic [6:0] S_BASE = 7'd0,
    parameter int         RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         score_rd_en,
    output logic [5:0]   score_rd_addr,
    input  logic [31:0]  score_rd_data,
    output logic [6:0]   S_mem_addr,
    output logic [127:0] S_mem_din,
    output logic         S_mem_wen,
    input  logic         S_mem_ready,
    output logic         busy,
    output logic         done
`ifdef SCORE_DRAIN_ROWMAX_EN
    ,
    output logic [31:0]  row_max,
    output logic         row_max_vld
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [2:0]   state_r;
    logic [3:0]   w_r;
    logic [1:0]   jc_r;
    logic [1:0]   wait_cnt_r;
    logic         start_d_r;
    logic         vld_pipe_r [RD_LAT];
    logic [1:0]   idx_pipe_r [RD_LAT];
    logic         start_rise_s;
    logic         cap_s;
    logic [127:0] lanes_nxt_s;

`ifdef SCORE_DRAIN_ROWMAX_EN
    // Sign-magnitude "strictly greater": -0 equals +0, NaN compares by raw magnitude.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            res = 1'b0;
        end else if (a[31] != b[31]) begin
            res = ~a[31];
        end else if (a[31] == 1'b0) begin
            res = (a[30:0] > b[30:0]);
        end else begin
            res = (a[30:0] < b[30:0]);
        end
        return res;
    endfunction

    // Lower lane wins ties because a later lane only replaces on strictly greater.
    function automatic logic [31:0] fp_max4(input logic [127:0] lanes);
        logic [31:0] best;
        best = lanes[31:0];
        for (int j = 1; j < 4; j++) begin
            if (fp_gt(lanes[32*j +: 32], best)) begin
                best = lanes[32*j +: 32];
            end else begin
                best = best;
            end
        end
        return best;
    endfunction
`endif

    // Start edge detect and lane capture from the delayed-read pipeline.
    always_comb begin
        start_rise_s = start & ~start_d_r;
        cap_s        = vld_pipe_r[RD_LAT-1];
        lanes_nxt_s  = S_mem_din;
        if (cap_s) begin
            lanes_nxt_s[{idx_pipe_r[RD_LAT-1], 5'd0} +: 32] = score_rd_data;
        end else begin
            lanes_nxt_s = S_mem_din;
        end
    end

    // Read-enable and lane-index delay line matching the register file latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_pipe_r[k] <= 1'b0;
                idx_pipe_r[k] <= 2'd0;
            end
        end else begin
            vld_pipe_r[0] <= score_rd_en;
            idx_pipe_r[0] <= score_rd_addr[1:0];
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_r[k] <= vld_pipe_r[k-1];
                idx_pipe_r[k] <= idx_pipe_r[k-1];
            end
        end
    end

    // Packed write data register; the final lane lands on the same edge WR is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            S_mem_din <= 128'd0;
`ifdef SCORE_DRAIN_ROWMAX_EN
            row_max   <= 32'd0;
`endif
        end else begin
            S_mem_din <= lanes_nxt_s;
`ifdef SCORE_DRAIN_ROWMAX_EN
            row_max   <= fp_max4(lanes_nxt_s);
`endif
        end
    end

`ifdef SCORE_DRAIN_ROWMAX_EN
    assign row_max_vld = S_mem_wen;
`endif

    // Drain sequencer: RD x4, WAIT x RD_LAT, WR until accepted, repeated for 16 words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            w_r           <= 4'd0;
            jc_r          <= 2'd0;
            wait_cnt_r    <= 2'd0;
            start_d_r     <= 1'b0;
            score_rd_en   <= 1'b0;
            score_rd_addr <= 6'd0;
            S_mem_addr    <= S_BASE;
            S_mem_wen     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            start_d_r <= start;
            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_r       <= ST_RD;
                        w_r           <= 4'd0;
                        jc_r          <= 2'd0;
                        busy          <= 1'b1;
                        score_rd_en   <= 1'b1;
                        score_rd_addr <= 6'd0;
                    end
                end
                ST_RD: begin
                    if (jc_r == 2'd3) begin
                        state_r     <= ST_WAIT;
                        score_rd_en <= 1'b0;
                        wait_cnt_r  <= 2'd0;
                    end else begin
                        jc_r          <= jc_r + 2'd1;
                        score_rd_addr <= {w_r, jc_r + 2'd1};
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_WR;
                        S_mem_wen  <= 1'b1;
                        S_mem_addr <= S_BASE + {3'd0, w_r};
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                ST_WR: begin
                    if (S_mem_ready) begin
                        S_mem_wen <= 1'b0;
                        if (w_r == 4'd15) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_r       <= ST_RD;
                            w_r           <= w_r + 4'd1;
                            jc_r          <= 2'd0;
                            score_rd_en   <= 1'b1;
                            score_rd_addr <= {w_r + 4'd1, 2'd0};
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    score_rd_en <= 1'b0;
                    S_mem_wen   <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/score_drain_4x128.md
Name: score_drain_4x128

Overview:
- Reads the 64-entry FP32 score register file after the score unit signals done, through its registered read port (score_rd_en / score_rd_addr / score_rd_data).
- Packs four j-scores per (head, i) into one 128-bit word and writes 16 words into the score SRAM for the downstream softmax stage.
- Sits between the score calculation unit and the softmax SRAM write port, with a valid/ready write handshake.

Parameters:
- S_BASE, 7'd0: SRAM word address of word 0.
- RD_LAT, 1: cycles from score_rd_en sampled to score_rd_data valid; legal values 1 or 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  score-unit done; only a rising edge starts a drain.
- score_rd_en  output  1  read enable to the score register file.
- score_rd_addr  output  6  read index = head*16 + i*4 + j.
- score_rd_data  input  32  FP32 score, valid RD_LAT cycles after the enable is sampled.
- S_mem_addr  output  7  SRAM word address.
- S_mem_din  output  128  packed word {s[j=3], s[j=2], s[j=1], s[j=0]}; lane j = bits [32j+31:32j].
- S_mem_wen  output  1  write request; held until accepted.
- S_mem_ready  input  1  write accepted on a cycle where S_mem_wen && S_mem_ready.
- busy  output  1  drain in progress.
- done  output  1  one-cycle pulse when all 16 words are written.

Behaviour:
- Reset (rst low, async): all outputs 0, S_mem_addr = S_BASE, state IDLE, counters 0, start edge-detect register 0.
- Word index w = 0..15, with head = w[3:2] and i = w[1:0]. S_mem_addr = S_BASE + w (7-bit wrap). Read indices are {head, i, j} for j = 0..3.
- IDLE: busy = 0. On a start rising edge: w = 0, busy = 1 next cycle, go to RD.
- RD (4 cycles): score_rd_en = 1, score_rd_addr = {w[3:2], w[1:0], jc}, jc = 0..3 in consecutive cycles. Then go to WAIT.
- Capture: the lane for read jc is loaded from score_rd_data exactly RD_LAT cycles after the enable is sampled. A delayed-enable/lane-index pipeline of depth RD_LAT tracks this.
- WAIT (RD_LAT cycles): score_rd_en = 0; the last lane is captured. Then go to WR.
- WR: S_mem_wen = 1; S_mem_addr and S_mem_din are registered and stable.
  - S_mem_ready low: hold WR with wen, addr and data unchanged.
  - On acceptance: S_mem_wen drops the next cycle. If w == 15, go to DONE; else w + 1 and go to RD.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Timing with S_mem_ready tied 1 and RD_LAT = 1: 4 + 1 + 1 = 6 cycles per word. done is high during the cycle that starts 96 edges after the start-sampling edge.
- Start rising edge while busy: ignored, not queued.
- score_rd_en is never asserted outside RD. score_rd_data is ignored when no capture is due.
- Reset asserted mid-drain: immediate return to reset values; no partial word written afterwards. A new start edge is needed.
- Scores are passed bit-exact: no FP arithmetic, NaN/denormal passed unchanged.

Optional Feature:
- Macro SCORE_DRAIN_ROWMAX_EN.
- Defined: adds outputs row_max [31:0] and row_max_vld (1), both reset 0.
  - row_max is the FP32 maximum of the four lanes, computed with a sign-magnitude compare.
  - -0 equals +0; on ties the lower j wins; NaN is treated by its raw bits as an ordinary magnitude.
  - Registered with S_mem_din, stable during WR. row_max_vld = S_mem_wen.
- Undefined: ports and compare logic are absent; all other behaviour is identical.

Test Plan:
- Basic drain: score_reg[k] = 32'h3F800000 + k, ready = 1, start pulse. Required: 16 writes; addr 0 data {3F800003, 3F800002, 3F800001, 3F800000}; addr 9 (head 2, i 1) lanes 3F800024..27; done at edge 96; busy low after.
- Backpressure: S_mem_ready low for 5 cycles on word 3. Required: wen, addr 3, data held stable all 5 cycles; exactly one write for addr 3; done delayed by 5 cycles.
- RD_LAT = 2 with S_BASE = 7'd16. Required: correct lanes at addrs 16..31; 7 cycles per word; done at edge 112.
- Start level held high for 200 cycles, plus a second edge mid-drain. Required: exactly one drain (16 writes, one done pulse).
- Reset pulse at cycle 40 of a drain. Required: all outputs 0 next cycle, no further wen; a new start gives a full, correct 16-word drain.
- With SCORE_DRAIN_ROWMAX_EN and word-0 lanes {BF800000, 00000000, 80000000, 40000000}: row_max = 40000000. With lanes {80000000, 00000000, BF800000, C0000000}: row_max = 80000000 (tie, lower j).
